// File: rtl/regfile_pkg.sv
// Shared types and constants for the multi-port integer register file.
package regfile_pkg;

    typedef enum logic {RF_SWEEP, RF_READY} rf_state_t;

    localparam int RF_XLEN_DEFAULT = 32;
    localparam int RF_NRD_MAX      = 4;

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: range check, hardwired-zero rule and optional write bypass.
// Bypass mux is present only when REGFILE_BYPASS_EN is defined.
module regfile_read_port import regfile_pkg::*; #(
    parameter int XLEN     = RF_XLEN_DEFAULT,
    parameter int NREGS    = 32,
    parameter int AW       = $clog2(NREGS),
    parameter int ZERO_REG = 1
) (
    input  logic [AW-1:0]                ra,
    input  logic [NREGS-1:0][XLEN-1:0]   mem,
    input  logic                         wr_ok,
    input  logic [AW-1:0]                wa,
    input  logic [XLEN-1:0]              wd,
    input  logic                         ready,
    output logic [XLEN-1:0]              rd
);

    localparam logic [AW:0] NREGS_W = (AW+1)'(NREGS);

    logic in_range;
    logic is_zero;
    logic hit;

    assign in_range = {1'b0, ra} < NREGS_W;
    assign is_zero  = (ZERO_REG != 0) && (ra == '0);

`ifdef REGFILE_BYPASS_EN
    // wr_ok already excludes x0 and out-of-range writes, so a hit implies a legal address
    assign hit = wr_ok && (ra == wa);
`else
    logic unused_wr;
    assign unused_wr = ^{wr_ok, wa, wd};
    assign hit       = 1'b0;
`endif

    always_comb begin
        rd = '0;
        if (ready && in_range && !is_zero) begin
            rd = hit ? wd : mem[ra];
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-read-port register file with post-reset clear sweep and ready flag.
// Optional same-cycle write-to-read bypass via REGFILE_BYPASS_EN.
module regfile_mp import regfile_pkg::*; #(
    parameter int XLEN     = RF_XLEN_DEFAULT,
    parameter int NREGS    = 32,
    parameter int AW       = $clog2(NREGS),
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear_req,
    input  logic [NRD*AW-1:0]     ra,
    output logic [NRD*XLEN-1:0]   rd,
    input  logic                  we,
    input  logic [AW-1:0]         wa,
    input  logic [XLEN-1:0]       wd,
    output logic                  ready
);

    localparam logic [AW:0]   NREGS_W  = (AW+1)'(NREGS);
    localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

    rf_state_t                  state_q, state_d;
    logic [AW-1:0]              idx_q, idx_d;
    logic [NREGS-1:0][XLEN-1:0] mem_q, mem_d;
    logic                       wr_ok;

    assign ready = (state_q == RF_READY);
    assign wr_ok = ready && we && ({1'b0, wa} < NREGS_W)
                   && !((ZERO_REG != 0) && (wa == '0));

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        mem_d   = mem_q;
        case (state_q)
            RF_SWEEP: begin
                mem_d[idx_q] = '0;
                if (idx_q == LAST_IDX) begin
                    state_d = RF_READY;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: begin
                // a write in the clear cycle still lands; the sweep then wipes it
                if (wr_ok) mem_d[wa] = wd;
                if (clear_req) state_d = RF_SWEEP;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RF_SWEEP;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rp
        regfile_read_port #(
            .XLEN     (XLEN),
            .NREGS    (NREGS),
            .AW       (AW),
            .ZERO_REG (ZERO_REG)
        ) u_rp (
            .ra    (ra[k*AW +: AW]),
            .mem   (mem_q),
            .wr_ok (wr_ok),
            .wa    (wa),
            .wd    (wd),
            .ready (ready),
            .rd    (rd[k*XLEN +: XLEN])
        );
    end

endmodule
